// File: rtl/pipeline_stall_ctrl.sv
// Load-use stall / flush control for the rv32i pipeline.
// Owns IF/ID, the ID/EX control half, PC write enable and event counters.
module pipeline_stall_ctrl #(
    parameter int          ISTRSIZE = 32,
    parameter int          ADDRSIZE = 32,
    parameter int          CTRLW    = 16,
    parameter logic [31:0] NOP      = 32'h00000013,
    parameter int          CNTW     = 16
) (
    input  logic                clk,
    input  logic                r,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDRSIZE-1:0] if_pc,
    input  logic [ISTRSIZE-1:0] if_instr,
    input  logic [CTRLW-1:0]    id_ctrl_in,
    output logic                pc_write,
    output logic [ADDRSIZE-1:0] id_pc,
    output logic [ISTRSIZE-1:0] id_instr,
    output logic                id_valid,
    output logic [CTRLW-1:0]    ex_ctrl,
    output logic                ex_bubble,
    output logic [CNTW-1:0]     stall_cnt,
    output logic [CNTW-1:0]     flush_cnt
);

    localparam logic [ISTRSIZE-1:0] NOP_I = ISTRSIZE'(NOP);

    // A flush redirects fetch, so it overrides a concurrent stall
    always_comb begin
        pc_write = !r && (flush || !stall);
    end

    // IF/ID register: flush discards, stall holds, else advance
    always_ff @(posedge clk) begin
        if (r) begin
            id_pc    <= '0;
            id_instr <= NOP_I;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_instr <= NOP_I;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_pc    <= if_pc;
            id_instr <= if_instr;
            id_valid <= 1'b1;
        end
    end

    // ID/EX control: zero bundle is a bubble with no side effects
    always_ff @(posedge clk) begin
        if (r) begin
            ex_ctrl   <= '0;
            ex_bubble <= 1'b0;
        end else if (flush || stall) begin
            ex_ctrl   <= '0;
            ex_bubble <= 1'b1;
        end else begin
            ex_ctrl   <= id_ctrl_in;
            ex_bubble <= !id_valid;
        end
    end

    // Saturating event counters; a stall under flush counts as flush only
    always_ff @(posedge clk) begin
        if (r) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl.
// Vector table plus saturation and reset sequences.
module tb_pipeline_stall_ctrl;

    localparam int CNTW = 4;

    logic        clk = 1'b0;
    logic        r, stall, flush;
    logic [31:0] if_pc, if_instr;
    logic [15:0] id_ctrl_in;
    logic        pc_write;
    logic [31:0] id_pc, id_instr;
    logic        id_valid;
    logic [15:0] ex_ctrl;
    logic        ex_bubble;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pipeline_stall_ctrl #(.CNTW(CNTW)) dut (
        .clk(clk), .r(r), .stall(stall), .flush(flush),
        .if_pc(if_pc), .if_instr(if_instr), .id_ctrl_in(id_ctrl_in),
        .pc_write(pc_write), .id_pc(id_pc), .id_instr(id_instr),
        .id_valid(id_valid), .ex_ctrl(ex_ctrl), .ex_bubble(ex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, stall, flush;
        logic [31:0] pc, instr;
        logic [15:0] ctrl;
        logic        e_pw;
        logic [31:0] e_pc, e_instr;
        logic        e_valid;
        logic [15:0] e_ctrl;
        logic        e_bub;
        int          e_sc, e_fc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rr, input logic st, input logic fl,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic [15:0] ct);
        r = rr; stall = st; flush = fl;
        if_pc = pc; if_instr = ins; id_ctrl_in = ct;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          r  st fl pc        instr         ctrl      pw  id_pc     id_instr      v  ex_ctrl   b  sc fc
        vecs[0]  = '{1, 1, 0, 32'h111, 32'hdeadbeef, 16'hffff, 0, 32'h0,  32'h13,       0, 16'h0,    0, 0, 0};
        vecs[1]  = '{1, 0, 1, 32'h222, 32'hcafef00d, 16'h5555, 0, 32'h0,  32'h13,       0, 16'h0,    0, 0, 0};
        vecs[2]  = '{0, 0, 0, 32'h40,  32'h00A00093, 16'h0123, 1, 32'h40, 32'h00A00093, 1, 16'h0123, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 32'h44,  32'h00208133, 16'h0123, 1, 32'h44, 32'h00208133, 1, 16'h0123, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 32'h48,  32'h11111111, 16'h0456, 0, 32'h44, 32'h00208133, 1, 16'h0,    1, 1, 0};
        vecs[5]  = '{0, 0, 0, 32'h48,  32'h22222222, 16'h0456, 1, 32'h48, 32'h22222222, 1, 16'h0456, 0, 1, 0};
        vecs[6]  = '{0, 1, 1, 32'h4c,  32'h33333333, 16'h0789, 1, 32'h48, 32'h13,       0, 16'h0,    1, 1, 1};
        vecs[7]  = '{0, 0, 0, 32'h80,  32'h44444444, 16'h0aaa, 1, 32'h80, 32'h44444444, 1, 16'h0aaa, 1, 1, 1};
        vecs[8]  = '{0, 0, 1, 32'h84,  32'h55555555, 16'h0bbb, 1, 32'h80, 32'h13,       0, 16'h0,    1, 1, 2};
        vecs[9]  = '{0, 1, 0, 32'h90,  32'h66666666, 16'h0ccc, 0, 32'h80, 32'h13,       0, 16'h0,    1, 2, 2};
        vecs[10] = '{0, 1, 0, 32'h90,  32'h66666666, 16'h0ccc, 0, 32'h80, 32'h13,       0, 16'h0,    1, 3, 2};
        vecs[11] = '{0, 0, 0, 32'h90,  32'h66666666, 16'h0ccc, 1, 32'h90, 32'h66666666, 1, 16'h0ccc, 1, 3, 2};
        vecs[12] = '{1, 1, 0, 32'h94,  32'h99999999, 16'h0eee, 0, 32'h0,  32'h13,       0, 16'h0,    0, 0, 0};
        vecs[13] = '{0, 0, 0, 32'ha0,  32'h77777777, 16'h0ddd, 1, 32'ha0, 32'h77777777, 1, 16'h0ddd, 1, 0, 0};

        drive(1, 0, 0, 0, 0, 0);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].r, vecs[i].stall, vecs[i].flush,
                  vecs[i].pc, vecs[i].instr, vecs[i].ctrl);
            #1;
            chk($sformatf("v%0d pc_write", i), 32'(pc_write), 32'(vecs[i].e_pw));
            step();
            chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].e_pc);
            chk($sformatf("v%0d id_instr", i), id_instr, vecs[i].e_instr);
            chk($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d ex_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].e_ctrl));
            chk($sformatf("v%0d ex_bubble", i), 32'(ex_bubble), 32'(vecs[i].e_bub));
            chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_sc));
            chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].e_fc));
        end

        // Stall counter saturation over 20 held stall cycles
        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 32'h100, 32'h12345678, 16'h0111);
            #1;
            chk($sformatf("sat_s%0d pc_write", i), 32'(pc_write), 32'd0);
            step();
            chk($sformatf("sat_s%0d stall_cnt", i), 32'(stall_cnt),
                (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            chk($sformatf("sat_s%0d ex_bubble", i), 32'(ex_bubble), 32'd1);
        end
        chk("sat_s flush_cnt", 32'(flush_cnt), 32'd0);
        chk("sat_s id_valid", 32'(id_valid), 32'd0);

        // Flush counter saturation; stall held too must not count
        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(0, i[0], 1, 32'h200, 32'h87654321, 16'h0222);
            step();
            chk($sformatf("sat_f%0d flush_cnt", i), 32'(flush_cnt),
                (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        chk("sat_f stall_cnt", 32'(stall_cnt), 32'd0);

        // Reset mid-flush clears counters, then normal load
        drive(1, 0, 1, 32'h300, 32'h0badc0de, 16'h0333);
        step();
        chk("rst_f flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_f ex_bubble", 32'(ex_bubble), 32'd0);
        drive(0, 0, 0, 32'h304, 32'h00500293, 16'h0444);
        step();
        chk("rst_f id_pc", id_pc, 32'h304);
        chk("rst_f id_instr", id_instr, 32'h00500293);
        chk("rst_f id_valid", 32'(id_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
